// File: rtl/sine_pwm_modulator.sv
// Table-driven sine source whose samples are compared against a free-running sawtooth
// carrier to give a glitch-free PWM bit; sw0_in picks one of two divider settings.
module sine_pwm_modulator #(
    parameter int unsigned      DEPTH   = 8,
    parameter int unsigned      WIDTH   = 12,
    parameter logic [DEPTH-1:0] CNTAMPL = 8'hFF,
    parameter int unsigned      DIVW    = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            sw0_in,
    input  logic [DIVW-1:0] sine_div0_in,
    input  logic [DIVW-1:0] sine_div1_in,
    input  logic [DIVW-1:0] pwm_div0_in,
    input  logic [DIVW-1:0] pwm_div1_in,
    output logic [WIDTH-1:0] sine_out,
    output logic            pwm_out
);

    localparam int unsigned ENTRIES = 1 << DEPTH;
    localparam int unsigned HALF    = ENTRIES / 2;
    localparam int unsigned QUARTER = ENTRIES / 4;
    localparam int unsigned MID     = 1 << (WIDTH - 1);
    localparam int unsigned AMP     = MID - 1;
    localparam int unsigned FRAC    = 100;
    localparam logic [WIDTH-1:0] SINE_MID = WIDTH'(MID);

    // floor(AMP * sin(pi*j/HALF)) for 0 <= j <= QUARTER, evaluated in 2^-100 fixed point
    function automatic logic [255:0] quarter_mag(input int unsigned j);
        logic [255:0] x;
        logic [255:0] x2;
        logic [255:0] term;
        logic [255:0] acc;
        x = (256'(j) * 256'd3141592653589793238462643 << FRAC)
            / (256'd1000000000000000000000000 << (DEPTH - 1));
        x2   = (x * x) >> FRAC;
        term = x;
        acc  = x;
        for (int n = 1; n <= 16; n++) begin
            term = ((term * x2) >> FRAC) / 256'(2 * n * (2 * n + 1));
            if (n[0]) begin
                acc = acc - term;
            end else begin
                acc = acc + term;
            end
        end
        return (acc * 256'(AMP)) >> FRAC;
    endfunction

    // Negative half needs a ceiling, i.e. one below the mirrored floor except where exact
    function automatic logic [WIDTH-1:0] rom_entry(input int unsigned k);
        int unsigned  j;
        logic [255:0] mag;
        logic [255:0] val;
        if (k < HALF) begin
            j = (k <= QUARTER) ? k : HALF - k;
        end else begin
            j = (k - HALF <= QUARTER) ? k - HALF : ENTRIES - k;
        end
        mag = quarter_mag(j);
        if (k < HALF) begin
            val = 256'(MID) + mag;
        end else if (j == 32'd0 || j == QUARTER) begin
            val = 256'(MID) - mag;
        end else begin
            val = 256'(MID) - mag - 256'd1;
        end
        return val[WIDTH-1:0];
    endfunction

    // A zero divider behaves like one: both give a terminal count of zero
    function automatic logic [DIVW-1:0] div_limit(input logic [DIVW-1:0] div);
        if (div == '0) begin
            return '0;
        end else begin
            return div - DIVW'(1);
        end
    endfunction

    logic [WIDTH-1:0] rom_s [ENTRIES];

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_rom
        localparam logic [WIDTH-1:0] ENTRY = rom_entry(gi);
        assign rom_s[gi] = ENTRY;
    end

    logic [DIVW-1:0]  sdiv_s, pdiv_s;
    logic             sine_term_s, pwm_term_s, wrap_s;
    logic [DIVW-1:0]  scnt_q, scnt_d, pcnt_q, pcnt_d;
    logic [DEPTH-1:0] index_q, index_d;
    logic [WIDTH-1:0] carrier_q, carrier_d;
    logic [WIDTH-1:0] sine_q, sine_d, latch_q, latch_d;
    logic             pwm_q, pwm_d;

    // Prescalers, phase/carrier advance, sample latch and compare
    always_comb begin
        sdiv_s      = sw0_in ? sine_div1_in : sine_div0_in;
        pdiv_s      = sw0_in ? pwm_div1_in  : pwm_div0_in;
        sine_term_s = (scnt_q >= div_limit(sdiv_s));
        pwm_term_s  = (pcnt_q >= div_limit(pdiv_s));
        wrap_s      = pwm_term_s && (carrier_q == {WIDTH{1'b1}});

        if (sine_term_s) begin
            scnt_d  = '0;
            index_d = (index_q == CNTAMPL) ? '0 : index_q + DEPTH'(1);
        end else begin
            scnt_d  = scnt_q + DIVW'(1);
            index_d = index_q;
        end

        if (pwm_term_s) begin
            pcnt_d    = '0;
            carrier_d = carrier_q + WIDTH'(1);
        end else begin
            pcnt_d    = pcnt_q + DIVW'(1);
            carrier_d = carrier_q;
        end

        // Capture the pre-edge sample so duty stays fixed for the whole carrier period
        if (wrap_s) begin
            latch_d = sine_q;
        end else begin
            latch_d = latch_q;
        end

        sine_d = rom_s[index_q];
        pwm_d  = (latch_q > carrier_q);
    end

    // State and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            scnt_q    <= '0;
            pcnt_q    <= '0;
            index_q   <= '0;
            carrier_q <= '0;
            sine_q    <= SINE_MID;
            latch_q   <= SINE_MID;
            pwm_q     <= 1'b0;
        end else begin
            scnt_q    <= scnt_d;
            pcnt_q    <= pcnt_d;
            index_q   <= index_d;
            carrier_q <= carrier_d;
            sine_q    <= sine_d;
            latch_q   <= latch_d;
            pwm_q     <= pwm_d;
        end
    end

    assign sine_out = sine_q;
    assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_sine_pwm_modulator.sv
// Self-checking bench: sine/PWM outputs against a behavioural model with a real-valued
// sine table, plus period, extreme-value and per-window duty properties.
module tb_sine_pwm_modulator;

    localparam int N  = 256;
    localparam int CW = 4096;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        sw0_in = 1'b0;
    logic [15:0] sine_div0_in = 16'd1;
    logic [15:0] sine_div1_in = 16'd1;
    logic [15:0] pwm_div0_in  = 16'd1;
    logic [15:0] pwm_div1_in  = 16'd1;
    logic [11:0] sine_out;
    logic        pwm_out;

    int errors = 0;
    int checks = 0;
    int rom_ref[N];
    int hist[$];

    int m_scnt, m_pcnt, m_idx, m_car, m_sine, m_latch, m_pwm;
    bit m_wrap;

    bit win_en = 1'b0;
    bit win_on = 1'b0;
    int win_pos, win_cnt, win_exp;

    sine_pwm_modulator dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .sw0_in       (sw0_in),
        .sine_div0_in (sine_div0_in),
        .sine_div1_in (sine_div1_in),
        .pwm_div0_in  (pwm_div0_in),
        .pwm_div1_in  (pwm_div1_in),
        .sine_out     (sine_out),
        .pwm_out      (pwm_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_scnt = 0; m_pcnt = 0; m_idx = 0; m_car = 0;
        m_sine = 2048; m_latch = 2048; m_pwm = 0; m_wrap = 1'b0;
    endtask

    // One clock of the behaviour described by the rate/phase/carrier rules
    task automatic model_step();
        int ds, dp, pre_sine, pre_latch, pre_car;
        ds = eff(sw0_in ? int'(sine_div1_in) : int'(sine_div0_in));
        dp = eff(sw0_in ? int'(pwm_div1_in) : int'(pwm_div0_in));
        pre_sine = m_sine; pre_latch = m_latch; pre_car = m_car;
        m_pwm  = (pre_latch > pre_car) ? 1 : 0;
        m_sine = rom_ref[m_idx];
        m_wrap = 1'b0;
        if (m_scnt + 1 >= ds) begin
            m_scnt = 0;
            m_idx  = (m_idx + 1) % N;
        end else begin
            m_scnt++;
        end
        if (m_pcnt + 1 >= dp) begin
            m_pcnt = 0;
            m_car  = (m_car + 1) % CW;
            if (m_car == 0) begin
                m_wrap  = 1'b1;
                m_latch = pre_sine;
            end
        end else begin
            m_pcnt++;
        end
    endtask

    // With a carrier step every clock, each window is high for exactly the latched sample
    task automatic window_track();
        if (win_on) begin
            if (win_pos == 0) check_val("run_start", int'(pwm_out), (win_exp > 0) ? 1 : 0);
            if (win_pos == win_exp && win_exp < CW) check_val("run_end", int'(pwm_out), 0);
            win_cnt += int'(pwm_out);
            win_pos++;
            if (win_pos == CW) begin
                check_val("duty", win_cnt, win_exp);
                win_on = 1'b0;
            end
        end
        if (m_wrap) begin
            win_on = 1'b1; win_pos = 0; win_cnt = 0; win_exp = m_latch;
        end
    endtask

    task automatic tick(input bit chk);
        @(posedge clk_in);
        if (rst_in) model_reset();
        else model_step();
        @(negedge clk_in);
        hist.push_back(int'(sine_out));
        if (chk) begin
            check_val("sine", int'(sine_out), m_sine);
            check_val("pwm", int'(pwm_out), m_pwm);
        end
        if (win_en) window_track();
    endtask

    initial begin
        int first;
        for (int k = 0; k < N; k++)
            rom_ref[k] = int'($floor(2048.0 + 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 256.0)));
        model_reset();

        // Reset held
        repeat (3) tick(1'b0);
        check_val("rst_sine", int'(sine_out), 2048);
        check_val("rst_pwm", int'(pwm_out), 0);
        rst_in = 1'b0;

        // Sine period and extremes at Ds = 1
        hist.delete();
        repeat (600) tick(1'b1);
        first = -1;
        for (int t = 0; t < 300; t++)
            if (first < 0 && hist[t] == 4095) first = t;
        check_val("max_found", (first >= 64) ? 1 : 0, 1);
        if (first >= 64) begin
            check_val("idx0_before_max", hist[first - 64], 2048);
            check_val("min_at_192", hist[first + 128], 1);
            check_val("max_repeat", hist[first + 256], 4095);
        end
        for (int t = 0; t < 300; t++) check_val("period256", hist[t + 256], hist[t]);

        // Rate switch 1 -> 2
        sine_div1_in = 16'd2;
        repeat (100) tick(1'b1);
        sw0_in = 1'b1;
        hist.delete();
        repeat (1100) tick(1'b1);
        for (int t = 0; t < 400; t++) check_val("period512", hist[t + 512], hist[t]);

        // Steady sample 2048 against a full-speed carrier
        rst_in = 1'b1;
        tick(1'b1);
        rst_in = 1'b0;
        sw0_in = 1'b0; sine_div0_in = 16'hFFFF; pwm_div0_in = 16'd1;
        win_en = 1'b1;
        repeat (3 * CW + 10) tick(1'b1);

        // Dynamic PWM: sine moving every clock
        sine_div0_in = 16'd1;
        repeat (3 * CW) tick(1'b1);
        win_en = 1'b0; win_on = 1'b0;

        // Zero dividers must match dividers of one, whichever side is selected
        sine_div0_in = 16'd0; pwm_div0_in = 16'd0;
        sine_div1_in = 16'd1; pwm_div1_in = 16'd1;
        for (int i = 0; i < 600; i++) begin
            sw0_in = 1'($urandom_range(0, 1));
            tick(1'b1);
        end

        // Random divider and select changes
        for (int s = 0; s < 10; s++) begin
            sw0_in       = 1'($urandom_range(0, 1));
            sine_div0_in = 16'($urandom_range(0, 5));
            sine_div1_in = 16'($urandom_range(0, 5));
            pwm_div0_in  = 16'($urandom_range(0, 5));
            pwm_div1_in  = 16'($urandom_range(0, 5));
            repeat ($urandom_range(50, 300)) tick(1'b1);
        end

        // Asynchronous reset mid-run, checked before the next rising edge
        for (int i = 0; i < 300 && sine_out == 12'd2048; i++) tick(1'b1);
        #2 rst_in = 1'b1;
        #1;
        check_val("async_sine", int'(sine_out), 2048);
        check_val("async_pwm", int'(pwm_out), 0);
        tick(1'b1);
        rst_in = 1'b0;
        repeat (200) tick(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sine_pwm_modulator.md
# sine_pwm_modulator

Digital sine-wave generator with a PWM modulator, in one clock domain. A table-driven sine source produces 12-bit unsigned amplitude samples. Those samples are compared against a free-running sawtooth carrier to produce a single-bit PWM output. A switch input selects between two sample-rate/carrier-rate divider settings at run time. It sits between board switches/clock and an output pin driving an external RC low-pass filter.

## Interface
- `DEPTH`, 8: phase-index width; the table holds 2^DEPTH = 256 samples per sine period.
- `WIDTH`, 12: amplitude and carrier width in bits.
- `CNTAMPL`, 8'hFF: terminal value of the phase index (2^DEPTH − 1).
- `DIVW`, 16: width of the divider inputs.
- `clk_in`  in  1: sole clock, rising edge.
- `rst_in`  in  1: asynchronous, active-high reset.
- `sw0_in`  in  1: rate select; 0 selects the `*_div0_in` inputs, 1 selects the `*_div1_in` inputs.
- `sine_div0_in`, `sine_div1_in`  in  DIVW: clocks per sine sample step.
- `pwm_div0_in`, `pwm_div1_in`  in  DIVW: clocks per carrier step.
- `sine_out`  out  WIDTH: current sine amplitude, unsigned offset binary, registered.
- `pwm_out`  out  1: PWM output, registered.

## Operation
- Sine ROM: entry k (0..255) = floor(2048 + 2047·sin(2πk/256)). This gives: entry 0 = 2048, entry 64 = 4095, entry 128 = 2048, entry 192 = 1.
- Sine prescaler: counter `scnt`. Effective divider Ds = selected sine divider, with 0 treated as 1.
  - Terminal condition: `scnt` ≥ Ds−1. On terminal, `scnt` ← 0 and phase index advances by 1.
  - Otherwise `scnt` increments.
- Phase index is DEPTH bits and wraps CNTAMPL → 0.
- `sine_out` ← ROM[index], registered every clock.
- Carrier prescaler: same rule as the sine prescaler, using effective divider Dp from the selected PWM divider.
  - On terminal, the WIDTH-bit carrier advances, wrapping 4095 → 0.
- Sample latch: when the carrier wraps to 0, the latch captures the current `sine_out`. Duty is therefore constant over each carrier period (glitch-free).
- `pwm_out` ← (latched sample > carrier), registered. Duty = sample/4096: sample 0 gives constant 0; sample 4095 gives high for 4095 of 4096 steps.
- `sw0_in` is used combinationally in each divider select.
  - A change takes effect at the next clock.
  - The ≥ terminal test guarantees no counter overrun when switching from a large divider to a small one.
- No handshakes. Divider inputs are treated as static/quasi-static; a change behaves exactly like a `sw0_in` change.

## Timing
- Reset (async assert, released synchronously by the system) sets:
  - `scnt`, pcnt, index, carrier = 0
  - `sine_out` = 2048
  - latched sample = 2048
  - `pwm_out` = 0
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Index update latency: with Ds = 1, index increments every clock. `sine_out` reflects the new index one clock after the index register changes.
- Sine period = 256·Ds clocks. Carrier period = 4096·Dp clocks.
- Latch-to-`pwm_out` latency: on the edge where the carrier becomes 0, the latch updates. `pwm_out` uses the new sample from the following edge.
- `pwm_out` lags the carrier/sample compare by exactly one clock.
- Simultaneous carrier wrap and sine step in the same edge: the latch captures the pre-edge `sine_out` value.

## Test plan
- Reset: hold `rst_in` high and check `sine_out` = 2048 and `pwm_out` = 0. Pulse `rst_in` asynchronously mid-run and check the outputs return to these values before the next edge.
- Sine period and extremes: `sw0_in` = 0, `sine_div0_in` = 1.
  - `sine_out` repeats every 256 clocks.
  - Max 4095 appears 64 clocks after index 0; min 1 appears at index 192.
- Rate switch: `sine_div0_in` = 1, `sine_div1_in` = 2. Toggle `sw0_in` 0 → 1 and check the sine period changes from 256 to 512 clocks with no skipped or repeated index beyond one step.
- PWM duty: `pwm_div0_in` = 1 with a steady sample of 2048. `pwm_out` is high for 2048 of every 4096 clocks, in a single contiguous run starting at carrier 0.
- Dynamic PWM: `sine_div0_in` = 1, `pwm_div0_in` = 1. Check that each 4096-clock carrier window has a high count equal to the `sine_out` value latched at that window's start.
- Divider zero: set the dividers to 0 and check the behaviour is identical to dividers of 1.
